// File: rtl/beta_pkg.sv
// Shared Beta definitions: load/store unit states and exception vectors.
package beta_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } lsu_state_t;

  // Vectors that control/datapath load into the PC; a fault from the LSU selects Illop.
  localparam logic [31:0] Reset = 32'h8000_0000;
  localparam logic [31:0] Illop = 32'h8000_0004;
  localparam logic [31:0] XAdr  = 32'h8000_0008;

endpackage

// File: rtl/beta_lsu.sv
// Beta load/store unit: turns a one-cycle LD/ST request into a req/ack bus
// transaction, stalling the CPU while it is outstanding and pulsing fault on
// misalignment, conflicting requests, bus error or timeout.
module beta_lsu
  import beta_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        RESET,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] MA,
  input  logic [31:0] MWD,
  output logic [31:0] MRD,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Count value seen during the last permitted silent BUSY cycle.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  lsu_state_t    state;
  lsu_state_t    state_next;
  logic [CW-1:0] count;
  logic          req_any;
  logic          req_ok;
  logic          req_bad;
  logic          timed_out;

  assign req_any   = mem_rd | mem_wr;
  assign req_ok    = (mem_rd ^ mem_wr) && (MA[1:0] == 2'b00);
  assign req_bad   = req_any && !req_ok;
  assign timed_out = (count == LAST);

  // Next-state and stall decode; error beats ack, ack beats timeout.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    if (RESET) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            state_next = BUSY;
            stall      = 1'b1;
          end else if (req_bad) begin
            state_next = FAULT;
            stall      = 1'b1;
          end
        end
        BUSY: begin
          stall = 1'b1;
          if (bus_err) begin
            state_next = FAULT;
          end else if (bus_ack) begin
            state_next = DONE;
          end else if (timed_out) begin
            state_next = FAULT;
          end
        end
        DONE:    state_next = IDLE;
        FAULT:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered bus outputs, fault pulse and timeout counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      fault     <= 1'b0;
      count     <= '0;
    end else begin
      bus_req <= (state_next == BUSY);
      fault   <= (state_next == FAULT);
      if ((state == IDLE) && (state_next == BUSY)) begin
        bus_addr  <= {MA[31:2], 2'b00};
        bus_wdata <= MWD;
        bus_we    <= mem_wr;
        count     <= '0;
      end else if ((state == BUSY) && (state_next == BUSY)) begin
        count <= count + 1'b1;
      end
    end
  end

  // Load data capture: only a clean ack of a read updates MRD.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      MRD <= 32'h0;
    end else if ((state == BUSY) && !RESET && bus_ack && !bus_err && !bus_we) begin
      MRD <= bus_rdata;
    end
  end

endmodule
